// File: rtl/bdd_search_pkg.sv
// Shared definitions for the BDD preimage search blocks.
//   state_e    : search controller states
//   DEF_IN_W   : default input width of the generated BDD function family
//   DEF_OUT_W  : default output width of the generated BDD function family
//   cnt_w()    : width of a counter able to hold 2^in_w hits
package bdd_search_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int DEF_IN_W  = 12;
  localparam int DEF_OUT_W = 9;

  // One extra bit so that "every candidate matched" (2^in_w) is representable.
  function automatic int cnt_w(input int in_w);
    return in_w + 1;
  endfunction

endpackage

// File: rtl/bdd_search_cmp.sv
// Masked output comparator.
// A response matches when every bit selected by the mask equals the target.
//   value_i  : function response under test
//   target_i : required pattern
//   mask_i   : 1 = bit compared, 0 = don't care
//   match_o  : high when all compared bits agree (purely combinational)
module bdd_search_cmp #(
  parameter int W = 9
) (
  input  logic [W-1:0] value_i,
  input  logic [W-1:0] target_i,
  input  logic [W-1:0] mask_i,
  output logic         match_o
);

  assign match_o = ((value_i ^ target_i) & mask_i) == '0;

endmodule

// File: rtl/bdd_preimage_search.sv
// Exhaustive preimage search over an attached combinational function.
// A request latches a target pattern and care mask; the block then walks
// every candidate input 0 .. 2^IN_W-1 through the function and streams each
// matching candidate over a valid/ready port, then pulses done with the hit
// count.
//   clk, rst          : clock, asynchronous active-high reset
//   req_valid/ready   : request handshake (ready only while idle)
//   req_target/mask   : pattern to match and care mask
//   abort             : end the running search early
//   fn_i / fn_o       : candidate to the function / its same-cycle response
//   hit_valid/ready   : hit stream handshake
//   hit_data/last     : matching candidate, flag for the all-ones candidate
//   done              : one-cycle end-of-search pulse
//   done_count        : hits in the finished search (valid with done)
//   done_aborted      : search ended by abort (valid with done)
module bdd_preimage_search
  import bdd_search_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int CNT_W = cnt_w(IN_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [OUT_W-1:0] req_target,
  input  logic [OUT_W-1:0] req_mask,
  input  logic             abort,
  output logic [IN_W-1:0]  fn_i,
  input  logic [OUT_W-1:0] fn_o,
  output logic             hit_valid,
  input  logic             hit_ready,
  output logic [IN_W-1:0]  hit_data,
  output logic             hit_last,
  output logic             done,
  output logic [CNT_W-1:0] done_count,
  output logic             done_aborted
);

  state_e             state_q;
  logic [IN_W-1:0]    cand_q;
  logic [OUT_W-1:0]   target_q;
  logic [OUT_W-1:0]   mask_q;
  logic [CNT_W-1:0]   hits_q;
  logic               hit_valid_q;
  logic [IN_W-1:0]    hit_data_q;
  logic               hit_last_q;
  logic               done_q;
  logic [CNT_W-1:0]   done_count_q;
  logic               done_aborted_q;

  logic               match;
  logic               cand_is_last;
  logic [IN_W-1:0]    cand_inc_d;
  logic [CNT_W-1:0]   hits_inc_d;

  bdd_search_cmp #(
    .W (OUT_W)
  ) u_cmp (
    .value_i  (fn_o),
    .target_i (target_q),
    .mask_i   (mask_q),
    .match_o  (match)
  );

  // End of space is detected on the current candidate, so cand never wraps.
  assign cand_is_last = &cand_q;
  assign cand_inc_d   = cand_q + IN_W'(1);
  assign hits_inc_d   = hits_q + CNT_W'(1);

  // The function sees 0 while idle and the live candidate otherwise; in HOLD
  // this keeps the function input equal to the pending hit.
  assign fn_i      = (state_q == IDLE) ? '0 : cand_q;
  assign req_ready = (state_q == IDLE);

  assign hit_valid    = hit_valid_q;
  assign hit_data     = hit_data_q;
  assign hit_last     = hit_last_q;
  assign done         = done_q;
  assign done_count   = done_count_q;
  assign done_aborted = done_aborted_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      cand_q         <= '0;
      target_q       <= '0;
      mask_q         <= '0;
      hits_q         <= '0;
      hit_valid_q    <= 1'b0;
      hit_data_q     <= '0;
      hit_last_q     <= 1'b0;
      done_q         <= 1'b0;
      done_count_q   <= '0;
      done_aborted_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            target_q <= req_target;
            mask_q   <= req_mask;
            cand_q   <= '0;
            hits_q   <= '0;
            state_q  <= SCAN;
          end
        end

        SCAN: begin
          // abort outranks a match in the same cycle: the match is not taken.
          if (abort) begin
            done_q         <= 1'b1;
            done_count_q   <= hits_q;
            done_aborted_q <= 1'b1;
            state_q        <= DONE;
          end else if (match) begin
            hit_data_q  <= cand_q;
            hit_last_q  <= cand_is_last;
            hit_valid_q <= 1'b1;
            hits_q      <= hits_inc_d;
            state_q     <= HOLD;
          end else if (cand_is_last) begin
            done_q         <= 1'b1;
            done_count_q   <= hits_q;
            done_aborted_q <= 1'b0;
            state_q        <= DONE;
          end else begin
            cand_q <= cand_inc_d;
          end
        end

        HOLD: begin
          // abort drops the pending hit even if it is being accepted now.
          if (abort) begin
            hit_valid_q    <= 1'b0;
            done_q         <= 1'b1;
            done_count_q   <= hits_q;
            done_aborted_q <= 1'b1;
            state_q        <= DONE;
          end else if (hit_valid_q && hit_ready) begin
            hit_valid_q <= 1'b0;
            if (hit_last_q) begin
              done_q         <= 1'b1;
              done_count_q   <= hits_q;
              done_aborted_q <= 1'b0;
              state_q        <= DONE;
            end else begin
              cand_q  <= cand_inc_d;
              state_q <= SCAN;
            end
          end
        end

        DONE: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
